// File: rtl/fifo_burst_reader.sv
// Burst reader that pops a fixed number of words from a synchronous FIFO
// and hands them downstream through a 2-entry skid buffer with a
// valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; empty buffer; start with len 0 just pulses done
// RUN     | popping until rd_left hits 0 and forwarding until out_left hits 0
module fifo_burst_reader #(
    parameter type T     = logic,
    parameter int  LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    input  T                 fifo_data,
    output logic             fifo_ren,
    output logic             out_valid,
    output T                 out_data,
    input  logic             out_ready
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic             state;
    logic [LEN_W-1:0] rd_left;
    logic [LEN_W-1:0] out_left;
    logic             done_q;
    logic [1:0]       count;
    T                 buf_q [2];
    logic             xfer;

    // Pop only from registered state so out_ready never reaches fifo_ren.
    assign fifo_ren  = (state == ST_RUN) & ~abort & (rd_left != '0) &
                       ~fifo_empty & (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = buf_q[0];
    assign xfer      = out_valid & out_ready;
    assign busy      = (state == ST_RUN);
    assign done      = done_q;

    // Sequencing FSM with the pop and transfer down-counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rd_left  <= '0;
            out_left <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (burst_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state    <= ST_RUN;
                            rd_left  <= burst_len;
                            out_left <= burst_len;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        rd_left  <= '0;
                        out_left <= '0;
                    end else begin
                        if (fifo_ren && rd_left != '0) begin
                            rd_left <= rd_left - LEN_W'(1);
                        end
                        if (xfer && out_left != '0) begin
                            out_left <= out_left - LEN_W'(1);
                            if (out_left == LEN_W'(1)) begin
                                state  <= ST_IDLE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Two-entry output buffer; entry 0 is always the oldest word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (state == ST_RUN && abort) begin
            count <= 2'd0;
        end else begin
            case ({fifo_ren, xfer})
                2'b10: begin
                    if (count == 2'd0) begin
                        buf_q[0] <= fifo_data;
                    end else begin
                        buf_q[1] <= fifo_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf_q[0] <= buf_q[1];
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        buf_q[0] <= fifo_data;
                    end else begin
                        buf_q[0] <= buf_q[1];
                        buf_q[1] <= fifo_data;
                    end
                end
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: directed scenarios plus randomized bursts,
// checked by a transaction-level scoreboard running on the falling edge.
module tb_fifo_burst_reader;

    localparam int SN = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] burst_len;
    logic       abort;
    logic       busy;
    logic       done;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_ren;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    logic [7:0] stream [SN];
    int         rd_idx = 0;
    int         avail  = 0;
    logic       stall  = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.T(logic [7:0]), .LEN_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .burst_len  (burst_len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_ren   (fifo_ren),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    // Upstream FIFO model: words are a fixed random stream, rd_idx is the head.
    assign fifo_empty = stall | (rd_idx >= avail);
    assign fifo_data  = (rd_idx < SN) ? stream[rd_idx] : 8'h00;

    always @(posedge clk) begin
        if (rst_n && fifo_ren) rd_idx <= rd_idx + 1;
    end

    task automatic chk(input string name, input logic ok, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Scoreboard / reference model.
    logic [7:0] exp_q [$];
    logic       m_busy = 1'b0;
    logic       m_done_next = 1'b0;
    int         m_left = 0;
    int         m_len = 0;
    int         m_pops = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done_next = 1'b0;
            prev_hold = 1'b0;
            exp_q.delete();
        end else begin
            chk("busy", busy == m_busy, int'(busy), int'(m_busy));
            chk("done", done == m_done_next, int'(done), int'(m_done_next));
            m_done_next = 1'b0;
            if (fifo_ren) begin
                chk("ren_while_empty", !fifo_empty, int'(fifo_empty), 0);
                chk("ren_outside_run", m_busy && !abort, int'(m_busy), 1);
                chk("pops_over_len", m_pops < m_len, m_pops + 1, m_len);
                m_pops++;
            end
            if (!m_busy) chk("valid_in_idle", !out_valid, int'(out_valid), 0);
            if (prev_hold) begin
                chk("hold_valid", out_valid, int'(out_valid), 1);
                chk("hold_data", out_data == prev_data, int'(out_data), int'(prev_data));
            end
            prev_hold = out_valid & !out_ready & !abort;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1'b0, int'(out_data), -1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data == e, int'(out_data), int'(e));
                end
            end
            if (m_busy) begin
                if (abort) begin
                    m_busy = 1'b0;
                    exp_q.delete();
                end else if (out_valid && out_ready) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done_next = 1'b1;
                    end
                end
            end else if (start) begin
                if (burst_len == 8'd0) begin
                    m_done_next = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_left = int'(burst_len);
                    m_len  = int'(burst_len);
                    m_pops = 0;
                    for (int i = 0; i < int'(burst_len); i++)
                        exp_q.push_back(stream[(rd_idx + i) % SN]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int len);
        start = 1'b1;
        burst_len = 8'(len);
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            cyc();
            n++;
        end
        chk(name, done, int'(done), 1);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            cyc();
            n++;
        end
        chk("idle_timeout", !busy, int'(busy), 0);
        cyc();
    endtask

    initial begin
        int n;
        int base;
        for (int i = 0; i < SN; i++) stream[i] = 8'($urandom);
        rst_n = 1'b0; start = 1'b0; burst_len = 8'd0; abort = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_busy", !busy, int'(busy), 0);
        chk("rst_done", !done, int'(done), 0);
        chk("rst_ren", !fifo_ren, int'(fifo_ren), 0);
        chk("rst_valid", !out_valid, int'(out_valid), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Four words ready, sink always ready: one pop and one transfer per cycle.
        avail = rd_idx + 4; out_ready = 1'b1;
        launch(4);
        for (int i = 0; i < 4; i++) begin
            chk("b4_ren", fifo_ren, int'(fifo_ren), 1);
            if (i > 0) chk("b4_valid", out_valid, int'(out_valid), 1);
            cyc();
        end
        chk("b4_last_valid", out_valid, int'(out_valid), 1);
        chk("b4_no_ren", !fifo_ren, int'(fifo_ren), 0);
        cyc();
        chk("b4_done", done, int'(done), 1);
        cyc();

        // Stalled sink: buffer fills with 2, then drains at full rate.
        avail = rd_idx + 6; out_ready = 1'b0; base = rd_idx;
        launch(6);
        repeat (6) cyc();
        chk("b6_two_pops", rd_idx - base == 2, rd_idx - base, 2);
        chk("b6_no_ren", !fifo_ren, int'(fifo_ren), 0);
        chk("b6_head", out_data == stream[base], int'(out_data), int'(stream[base]));
        out_ready = 1'b1;
        wait_done("b6_done", 20, n);
        chk("b6_drain_cycles", n == 6, n, 6);
        cyc();

        // Upstream empty for a while after start.
        stall = 1'b1; avail = rd_idx + 3;
        launch(3);
        for (int i = 0; i < 5; i++) begin
            chk("empty_ren", !fifo_ren, int'(fifo_ren), 0);
            chk("empty_valid", !out_valid, int'(out_valid), 0);
            chk("empty_busy", busy, int'(busy), 1);
            cyc();
        end
        stall = 1'b0;
        wait_done("empty_done", 20, n);
        cyc();

        // Zero-length burst.
        launch(0);
        chk("zero_done", done, int'(done), 1);
        chk("zero_busy", !busy, int'(busy), 0);
        cyc();
        chk("zero_done_once", !done, int'(done), 0);

        // Abort with two words buffered, then a normal burst.
        avail = rd_idx + 8; out_ready = 1'b0; base = rd_idx;
        launch(8);
        repeat (4) cyc();
        chk("ab_valid", out_valid, int'(out_valid), 1);
        abort = 1'b1;
        #1;
        chk("ab_no_pop", !fifo_ren, int'(fifo_ren), 0);
        cyc();
        abort = 1'b0;
        chk("ab_flushed", !out_valid, int'(out_valid), 0);
        chk("ab_busy", !busy, int'(busy), 0);
        chk("ab_no_done", !done, int'(done), 0);
        chk("ab_pops", rd_idx - base == 2, rd_idx - base, 2);
        out_ready = 1'b1; avail = rd_idx + 3;
        launch(3);
        wait_done("ab_after_done", 20, n);
        cyc();

        // Asynchronous reset in the middle of a burst.
        avail = rd_idx + 8; out_ready = 1'b0;
        launch(8);
        repeat (2) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", !busy, int'(busy), 0);
        chk("rst_mid_valid", !out_valid, int'(out_valid), 0);
        chk("rst_mid_ren", !fifo_ren, int'(fifo_ren), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        out_ready = 1'b1; avail = rd_idx + 2;
        launch(2);
        wait_done("rst_after_done", 20, n);
        cyc();

        // Randomized bursts with stalls on both sides, stray starts and aborts.
        for (int b = 0; b < 60; b++) begin
            int len;
            len = int'($urandom_range(0, 10));
            launch(len);
            for (int c = 0; c < 300 && busy; c++) begin
                out_ready = ($urandom_range(0, 9) < 7);
                stall = ($urandom_range(0, 3) == 0);
                if (avail < SN - 4) avail = avail + int'($urandom_range(0, 2));
                abort = ($urandom_range(0, 39) == 0);
                if (abort) out_ready = 1'b0;
                start = ($urandom_range(0, 19) == 0);
                burst_len = 8'($urandom_range(0, 10));
                cyc();
            end
            abort = 1'b0; start = 1'b0; stall = 1'b0;
            if (avail < rd_idx + 12) avail = rd_idx + 12;
            settle();
        end

        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
